regmap_host_if: RTL

- Initiator side of the register-map access port.
- Accepts host commands (read or write, address, data) over a valid/ready stream and drives the register map's wr_en/wr_addr/wr_data and rd_en/rd_addr/rd_data port.
- Returns one response per command over a second valid/ready stream.
- Sits between the host command decoder and the register map. Serialises accesses, enforces read latency and flags out-of-range addresses.

---
 rtl/regmap_pkg.sv | 34 +++
 rtl/regmap_rsp_slice.sv | 49 ++++
 rtl/regmap_host_if.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/regmap_pkg.sv
// -----------------------------------------------------------------------------
// regmap_pkg
// Shared types and constants for the register-map access port: the host
// interface FSM states, the error data word, and the response record used by
// the register map and its clients.
// -----------------------------------------------------------------------------
package regmap_pkg;

  // Data returned with every out-of-range response.
  localparam logic [31:0] ERR_DATA = 32'hDEADDEAD;

  // Width of the read-latency counter; holds RD_LATENCY values 1..4.
  localparam int LAT_CNT_W = 3;

  // Data width of the shared response record (the register map's native width).
  localparam int RSP_DATA_W = 32;

  // Explicit encodings so the state values stay stable across tool flows.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Response record; field order is the packed layout {rdata, err, write}.
  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
    logic                  write;
  } rsp_t;

endpackage

// File: rtl/regmap_rsp_slice.sv
// -----------------------------------------------------------------------------
// regmap_rsp_slice
// Single-entry response holding register with valid/ready on both sides.
// Accepts a new entry only while empty, so the held entry never changes
// while out_valid_o is high.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid_i/o     producer side: entry offered / slot free
//   in_data_i        entry payload
//   out_valid_o      entry held
//   out_ready_i      consumer takes the entry
//   out_data_o       held payload
// -----------------------------------------------------------------------------
module regmap_rsp_slice
  import regmap_pkg::*;
#(
  parameter int W = $bits(rsp_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = !valid_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/regmap_host_if.sv
// -----------------------------------------------------------------------------
// regmap_host_if
// Initiator side of the register-map access port. Takes one host command at a
// time, issues a single wr_en or rd_en strobe, waits out the read latency and
// returns exactly one response. Out-of-range addresses are answered with
// err = 1 and ERR_DATA without touching the register map.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command stream (cmd_write, cmd_addr, cmd_wdata)
//   rsp_valid/rsp_ready        response stream (rsp_rdata, rsp_err, rsp_write)
//   wr_en, wr_addr, wr_data    register-map write port
//   rd_en, rd_addr, rd_data    register-map read port
// -----------------------------------------------------------------------------
module regmap_host_if #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter int                    RD_LATENCY = 1,   // legal range 1..4
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(regmap_pkg::ERR_DATA)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_write,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  localparam int               CNT_W      = regmap_pkg::LAT_CNT_W;
  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(RD_LATENCY);
  localparam logic [31:0]      NUM_REGS_U = 32'(NUM_REGS);

  regmap_pkg::state_e    state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cmd_ready_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  // Response payload packed as {rdata, err, write}.
  logic                  push_valid, push_ready;
  logic [DATA_WIDTH+1:0] push_data, rsp_data;

  logic cmd_fire, addr_ok;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  // Unsigned compare on a zero-extended address, so all-ones is out of range.
  assign addr_ok  = 32'(cmd_addr) < NUM_REGS_U;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    push_valid = 1'b0;
    push_data  = '0;

    case (state_q)
      regmap_pkg::IDLE: begin
        if (cmd_fire) begin
          if (!addr_ok) begin
            // Answered directly; the register map never sees this command.
            push_valid = 1'b1;
            push_data  = {ERR_DATA, 1'b1, cmd_write};
            if (push_ready) state_d = regmap_pkg::RESP;
          end else if (cmd_write) begin
            wr_addr_d = cmd_addr;
            wr_data_d = cmd_wdata;
            state_d   = regmap_pkg::WRITE;
          end else begin
            rd_addr_d = cmd_addr;
            state_d   = regmap_pkg::READ;
          end
        end
      end
      regmap_pkg::WRITE: begin
        push_valid = 1'b1;
        push_data  = {{DATA_WIDTH{1'b0}}, 1'b0, 1'b1};
        if (push_ready) state_d = regmap_pkg::RESP;
      end
      regmap_pkg::READ: begin
        cnt_d   = LAT_LOAD;
        state_d = regmap_pkg::WAIT;
      end
      regmap_pkg::WAIT: begin
        // A count of 1 here means this is the cycle the count reaches 0:
        // rd_data is valid now, RD_LATENCY cycles after the rd_en cycle.
        if (cnt_q == CNT_W'(1)) begin
          push_valid = 1'b1;
          push_data  = {rd_data, 1'b0, 1'b0};
          if (push_ready) state_d = regmap_pkg::RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      regmap_pkg::RESP: begin
        if (rsp_valid && rsp_ready) state_d = regmap_pkg::IDLE;
      end
      default: state_d = regmap_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= regmap_pkg::IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking ones would make results depend on statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // Registered so it is 0 throughout reset and rises on the first edge.
      cmd_ready_q <= (state_d == regmap_pkg::IDLE);
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  regmap_rsp_slice #(
    .W (DATA_WIDTH + 2)
  ) u_rsp_slice (
    .clk         (clk),
    .rst_n       (rst),
    .in_valid_i  (push_valid),
    .in_ready_o  (push_ready),
    .in_data_i   (push_data),
    .out_valid_o (rsp_valid),
    .out_ready_i (rsp_ready),
    .out_data_o  (rsp_data)
  );

  assign {rsp_rdata, rsp_err, rsp_write} = rsp_data;

  assign cmd_ready = cmd_ready_q;
  assign wr_en     = (state_q == regmap_pkg::WRITE);
  assign rd_en     = (state_q == regmap_pkg::READ);
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;

endmodule
